// File: rtl/stage1if.sv
// Instruction Fetch stage: pairs the latched PC with its instruction word and buffers
// the pair in a small FIFO feeding Decode over a valid/ready handshake.
module stage1if #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 24,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               ready_out,
  output logic               valid_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instr_out,
  input  logic               ready_in,
  input  logic               flush_in,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W+INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CW-1:0]             count;
  logic                      push;
  logic                      pop;

  // Handshake flags depend on registered count only, so ready_out never sees ready_in.
  assign ready_out = (count != FULL);
  assign valid_out = (count != '0);
  assign push      = valid_in & ready_out & ~flush_in;
  assign pop       = valid_out & ready_in & ~flush_in;

  assign {pc_out, instr_out} = valid_out ? mem[rd_ptr] : '0;

  // Storage is deliberately left out of reset; valid_out masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {pc_in, mem_rdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fetch_count <= '0;
    end else if (flush_in) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        fetch_count <= fetch_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_stage1if.sv
// Randomised and directed bench for stage1if: a queue-based model checked every cycle,
// plus literal expectations for the key scenarios, on default and 4-bit counter builds.
module tb_stage1if;

  localparam int AW    = 24;
  localparam int IW    = 24;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [AW-1:0] pc_in;
  logic [IW-1:0] mem_rdata;
  logic          ready_in;
  logic          flush_in;

  logic          ready_out, valid_out;
  logic [AW-1:0] pc_out;
  logic [IW-1:0] instr_out;
  logic [15:0]   fetch_count;

  logic          ready_out4, valid_out4;
  logic [AW-1:0] pc_out4;
  logic [IW-1:0] instr_out4;
  logic [3:0]    fetch_count4;

  int compared   = 0;
  int mismatched = 0;

  logic [AW+IW-1:0] mq [$];
  int unsigned      pops = 0;

  stage1if #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pc_in(pc_in), .mem_rdata(mem_rdata),
    .ready_out(ready_out), .valid_out(valid_out), .pc_out(pc_out), .instr_out(instr_out),
    .ready_in(ready_in), .flush_in(flush_in), .fetch_count(fetch_count)
  );

  stage1if #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pc_in(pc_in), .mem_rdata(mem_rdata),
    .ready_out(ready_out4), .valid_out(valid_out4), .pc_out(pc_out4), .instr_out(instr_out4),
    .ready_in(ready_in), .flush_in(flush_in), .fetch_count(fetch_count4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue bounded at DEPTH plus a pop tally.
  always @(posedge clk or negedge rst_n) begin : model
    bit push, pop;
    if (!rst_n) begin
      mq.delete();
      pops = 0;
    end else begin
      push = valid_in && (mq.size() < DEPTH) && !flush_in;
      pop  = (mq.size() > 0) && ready_in && !flush_in;
      if (flush_in) begin
        mq.delete();
      end else begin
        if (pop) begin
          void'(mq.pop_front());
          pops++;
        end
        if (push) mq.push_back({pc_in, mem_rdata});
      end
    end
  end

  always @(negedge clk) begin : compare
    logic             ev, er;
    logic [AW+IW-1:0] head;
    logic [15:0]      fc;
    ev   = (mq.size() != 0);
    er   = (mq.size() != DEPTH);
    head = ev ? mq[0] : '0;
    fc   = pops[15:0];
    checkOutput("valid_out",    64'(valid_out),    64'(ev));
    checkOutput("ready_out",    64'(ready_out),    64'(er));
    checkOutput("pc_out",       64'(pc_out),       64'(head[AW+IW-1:IW]));
    checkOutput("instr_out",    64'(instr_out),    64'(head[IW-1:0]));
    checkOutput("fetch_count",  64'(fetch_count),  64'(fc));
    checkOutput("valid_out4",   64'(valid_out4),   64'(ev));
    checkOutput("ready_out4",   64'(ready_out4),   64'(er));
    checkOutput("pc_out4",      64'(pc_out4),      64'(head[AW+IW-1:IW]));
    checkOutput("fetch_count4", 64'(fetch_count4), 64'(fc[3:0]));
  end

  // Drive one cycle of inputs (called at posedge+1) and return at the next posedge+1.
  task automatic applyStimulus(input logic v, input logic [AW-1:0] pc, input logic [IW-1:0] d,
                               input logic rdy, input logic fl);
    valid_in  = v;
    pc_in     = pc;
    mem_rdata = d;
    ready_in  = rdy;
    flush_in  = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; pc_in = '0; mem_rdata = '0; ready_in = 1'b0; flush_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst valid_out", 64'(valid_out), 64'd0);
    checkOutput("rst ready_out", 64'(ready_out), 64'd1);
    checkOutput("rst fetch_count", 64'(fetch_count), 64'd0);
    checkOutput("rst pc_out", 64'(pc_out), 64'd0);

    applyStimulus(1, 24'h000010, 24'hABCDEF, 1, 0);
    checkOutput("single valid", 64'(valid_out), 64'd1);
    checkOutput("single pc", 64'(pc_out), 64'h10);
    checkOutput("single instr", 64'(instr_out), 64'hABCDEF);
    applyStimulus(0, 0, 'x, 1, 0);
    checkOutput("single drained", 64'(valid_out), 64'd0);
    checkOutput("single count", 64'(fetch_count), 64'd1);

    applyStimulus(1, 24'h20, 24'h111, 0, 0);
    applyStimulus(1, 24'h21, 24'h222, 0, 0);
    checkOutput("bp full", 64'(ready_out), 64'd0);
    applyStimulus(1, 24'h22, 24'h333, 0, 0);
    checkOutput("bp still full", 64'(ready_out), 64'd0);
    checkOutput("bp head", 64'(pc_out), 64'h20);
    applyStimulus(0, 0, 'x, 1, 0);
    checkOutput("bp second", 64'(pc_out), 64'h21);
    checkOutput("bp ready back", 64'(ready_out), 64'd1);
    applyStimulus(0, 0, 'x, 1, 0);
    checkOutput("bp 0x22 dropped", 64'(valid_out), 64'd0);
    checkOutput("bp count", 64'(fetch_count), 64'd3);

    for (int i = 0; i < 100; i++) applyStimulus(1, AW'(i), IW'($urandom), 1, 0);
    applyStimulus(0, 0, 'x, 1, 0);
    checkOutput("stream count", 64'(fetch_count), 64'd103);
    checkOutput("stream count4", 64'(fetch_count4), 64'd7);

    applyStimulus(1, 24'h40, 24'h444, 0, 0);
    applyStimulus(1, 24'h41, 24'h555, 0, 0);
    applyStimulus(1, 24'h55, 24'h666, 0, 1);
    checkOutput("flush valid", 64'(valid_out), 64'd0);
    checkOutput("flush ready", 64'(ready_out), 64'd1);
    checkOutput("flush count", 64'(fetch_count), 64'd103);
    applyStimulus(1, 24'h77, 24'h123, 1, 0);
    checkOutput("post-flush pc", 64'(pc_out), 64'h77);
    applyStimulus(0, 0, 'x, 1, 0);

    applyStimulus(1, 24'h90, 24'h1, 1, 0);
    applyStimulus(1, 24'h91, 24'h2, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst valid", 64'(valid_out), 64'd0);
    checkOutput("async rst valid4", 64'(valid_out4), 64'd0);
    checkOutput("async rst count", 64'(fetch_count), 64'd0);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) applyStimulus(1, AW'(i + 'h100), IW'($urandom), 1, 0);
    applyStimulus(0, 0, 'x, 1, 0);
    checkOutput("wrap count4", 64'(fetch_count4), 64'd1);
    checkOutput("wrap count16", 64'(fetch_count), 64'd17);

    for (int i = 0; i < 3000; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(v, AW'($urandom), v ? IW'($urandom) : 'x,
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
    end
    applyStimulus(0, 0, 'x, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
